// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: shared widths, the canonical NOP and the fetch/decode entry type.
package fetch_decode_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fd_entry_t;

    // Full-width RV32 encodings have both low bits set; anything else is compressed or bogus.
    function automatic logic is_rv32_encoding(input logic [XLEN-1:0] instr);
        return instr[1:0] == 2'b11;
    endfunction
endpackage

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular {pc, instr} buffer between fetch and decode.
// Presents the oldest entry, or a NOP when empty; flush discards everything.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN = fetch_decode_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_decode_pkg::NOP_INSTR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    input  logic [XLEN-1:0]              enq_pc,
    input  logic [XLEN-1:0]              enq_instr,
    output logic                         enq_ready,
    output logic                         deq_valid,
    output logic [XLEN-1:0]              deq_pc,
    output logic [XLEN-1:0]              deq_instr,
    output logic                         deq_illegal,
    input  logic                         deq_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    import fetch_decode_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fd_entry_t mem [DEPTH];
    fd_entry_t head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic empty, full, enq_fire, deq_fire;

    // The extra pointer MSB separates the full case from the empty case.
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign enq_ready = !full;
    assign deq_valid = !empty && !flush;
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_valid && deq_ready;
    assign count     = CW'(wr_ptr - rd_ptr);

    assign head        = mem[rd_ptr[AW-1:0]];
    assign deq_pc      = empty ? '0 : head.pc;
    assign deq_instr   = empty ? NOP_INSTR : head.instr;
    assign deq_illegal = !empty && !is_rv32_encoding(head.instr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_ptr[AW-1:0]] <= '{pc: enq_pc, instr: enq_instr};
    end
endmodule
